// File: rtl/conv_pkg.sv
// Shared widths, tile geometry, FSM encoding and output saturation for the CONV job controller.
package conv_pkg;
    localparam int DIN_W  = 8;
    localparam int DOUT_W = 20;
    localparam int ACC_W  = 24;
    localparam int TILE_N = 36;
    localparam int RES_N  = 16;

    typedef enum logic [3:0] {
        S_IDLE, S_PREF, S_STREAM, S_WAIT, S_SKIP, S_CAPT, S_WRITE, S_DONE, S_ERR
    } state_e;

    // In range exactly when every bit above the output sign bit matches it.
    function automatic logic [DOUT_W-1:0] sat_acc(input logic [ACC_W-1:0] v);
        logic hi_zero;
        logic hi_ones;
        hi_zero = ~|v[ACC_W-1:DOUT_W-1];
        hi_ones = &v[ACC_W-1:DOUT_W-1];
        if (hi_zero || hi_ones) return v[DOUT_W-1:0];
        else if (v[ACC_W-1]) return {1'b1, {(DOUT_W-1){1'b0}}};
        else return {1'b0, {(DOUT_W-1){1'b1}}};
    endfunction
endpackage

// File: rtl/conv_psum_bank.sv
// Per-output partial sums across channels: clear, indexed accumulate, indexed saturated read.
module conv_psum_bank
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              acc_en_i,
    input  logic [3:0]        idx_i,
    input  logic [DOUT_W-1:0] acc_data_i,
    output logic [DOUT_W-1:0] rd_sat_o
);
    logic [ACC_W-1:0] psum_q [RES_N];
    logic [ACC_W-1:0] sext_acc;

    assign sext_acc = {{(ACC_W-DOUT_W){acc_data_i[DOUT_W-1]}}, acc_data_i};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RES_N; i++) psum_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < RES_N; i++) psum_q[i] <= '0;
        end else if (acc_en_i) begin
            psum_q[idx_i] <= psum_q[idx_i] + sext_acc;
        end
    end

    assign rd_sat_o = sat_acc(psum_q[idx_i]);
endmodule

// File: rtl/conv_job_ctrl.sv
// Job sequencer for the CONV engine: per-channel fetch/stream/wait/capture, then saturated write-out.
module conv_job_ctrl
    import conv_pkg::*;
#(
    parameter int MAX_CH  = 16,
    parameter int CH_W    = 5,
    parameter int IN_AW   = 10,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_start,
    input  logic [CH_W-1:0]   job_nch,
    output logic              job_busy,
    output logic              job_done,
    output logic              job_err,
    output logic              in_rd_en,
    output logic [IN_AW-1:0]  in_addr,
    input  logic [DIN_W-1:0]  in_data,
    output logic              CONV_start,
    output logic [DIN_W-1:0]  CONV_iData,
    input  logic              CONV_finish,
    input  logic [DOUT_W-1:0] CONV_oData,
    output logic              out_we,
    output logic [3:0]        out_addr,
    output logic [DOUT_W-1:0] out_data
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   nch_q, nch_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [DIN_W-1:0]  idata_q, idata_d;
    logic [5:0]        rd_k;
    logic              psum_clr;
    logic [DOUT_W-1:0] rd_sat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            nch_q   <= '0;
            ch_q    <= '0;
            cnt_q   <= '0;
            wdog_q  <= '0;
            idata_q <= '0;
        end else begin
            state_q <= state_d;
            nch_q   <= nch_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            wdog_q  <= wdog_d;
            idata_q <= idata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        nch_d   = nch_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        wdog_d  = wdog_q;
        case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    if (job_nch != '0 && job_nch <= CH_W'(MAX_CH)) begin
                        state_d = S_PREF;
                        nch_d   = job_nch;
                        ch_d    = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_PREF: begin
                if (cnt_q == 6'd1) begin
                    state_d = S_STREAM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_STREAM: begin
                if (cnt_q == 6'(TILE_N - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    wdog_d  = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            // Finish is checked before the watchdog so a last-cycle finish still completes.
            S_WAIT: begin
                if (CONV_finish) state_d = S_SKIP;
                else if (wdog_q == WD_W'(TIMEOUT - 1)) state_d = S_ERR;
                else wdog_d = wdog_q + 1'b1;
            end
            S_SKIP: begin
                state_d = S_CAPT;
                cnt_d   = '0;
            end
            S_CAPT: begin
                if (cnt_q == 6'(RES_N - 1)) begin
                    cnt_d = '0;
                    if (ch_q == nch_q - CH_W'(1)) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_PREF;
                        ch_d    = ch_q + CH_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_WRITE: begin
                if (cnt_q == 6'(RES_N - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Reads run two ahead, so the sample arriving now is the one streamed next cycle.
        idata_d = (state_d == S_STREAM) ? in_data : '0;
    end

    always_comb begin
        job_busy   = 1'b0;
        job_done   = 1'b0;
        job_err    = 1'b0;
        in_rd_en   = 1'b0;
        in_addr    = '0;
        CONV_start = 1'b0;
        out_we     = 1'b0;
        out_addr   = '0;
        out_data   = '0;
        rd_k       = (state_q == S_PREF) ? cnt_q : cnt_q + 6'd2;
        case (state_q)
            S_IDLE: ;
            S_PREF: begin
                job_busy = 1'b1;
                in_rd_en = 1'b1;
            end
            S_STREAM: begin
                job_busy   = 1'b1;
                CONV_start = 1'b1;
                in_rd_en   = (cnt_q <= 6'(TILE_N - 3));
            end
            S_WRITE: begin
                job_busy = 1'b1;
                out_we   = 1'b1;
                out_addr = cnt_q[3:0];
                out_data = rd_sat;
            end
            S_DONE:  job_done = 1'b1;
            S_ERR:   job_err  = 1'b1;
            default: job_busy = 1'b1;
        endcase
        if (in_rd_en) in_addr = IN_AW'(ch_q) * IN_AW'(TILE_N) + IN_AW'(rd_k);
    end

    assign CONV_iData = idata_q;
    assign psum_clr   = (state_q == S_IDLE) && (state_d == S_PREF);

    conv_psum_bank u_psum (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (psum_clr),
        .acc_en_i   (state_q == S_CAPT),
        .idx_i      (cnt_q[3:0]),
        .acc_data_i (CONV_oData),
        .rd_sat_o   (rd_sat)
    );
endmodule

// File: tb/tb_conv_job_ctrl.sv
// Bench for conv_job_ctrl: input RAM and CONV behavioural models, golden conv+sum scoreboard.
`timescale 1ns/1ps
module tb_conv_job_ctrl;
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               job_start = 1'b0;
    logic [4:0]         job_nch = '0;
    logic               job_busy, job_done, job_err;
    logic               in_rd_en;
    logic [9:0]         in_addr;
    logic signed [7:0]  in_data = '0;
    logic               CONV_start;
    logic signed [7:0]  CONV_iData;
    logic               CONV_finish = 1'b0;
    logic signed [19:0] CONV_oData = '0;
    logic               out_we;
    logic [3:0]         out_addr;
    logic signed [19:0] out_data;

    conv_job_ctrl dut (
        .clk(clk), .reset(reset), .job_start(job_start), .job_nch(job_nch),
        .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
        .in_rd_en(in_rd_en), .in_addr(in_addr), .in_data(in_data),
        .CONV_start(CONV_start), .CONV_iData(CONV_iData), .CONV_finish(CONV_finish),
        .CONV_oData(CONV_oData), .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    logic signed [7:0] mem [1024];
    int kern [9];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (in_rd_en) in_data <= mem[in_addr];

    function automatic int conv_at(input int t [36], input int p);
        int r = p / 4;
        int c = p % 4;
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += kern[i*3+j] * t[(r+i)*6 + c + j];
        return s;
    endfunction

    function automatic int sat20(input int v);
        if (v > 524287) return 524287;
        if (v < -524288) return -524288;
        return v;
    endfunction

    // CONV engine model: collect 36 samples, finish after a delay, then stream 16 results.
    int cm_phase = 0, cm_cnt = 0, cm_d = 0, cm_j = 0, cm_brk = 0;
    int cm_delay = 0;
    bit cm_hang = 0, cm_spur = 0;
    int cm_tile [36];
    int cm_res [16];
    always @(negedge clk) begin
        if (!reset) begin
            cm_phase = 0; cm_cnt = 0; CONV_finish = 1'b0; CONV_oData = '0;
        end else begin
            case (cm_phase)
                0: begin
                    CONV_finish = 1'b0;
                    if (CONV_start) begin
                        cm_tile[cm_cnt] = int'(CONV_iData);
                        cm_cnt++;
                        if (cm_spur && cm_cnt == 10) CONV_finish = 1'b1;
                        if (cm_cnt == 36) begin
                            for (int p = 0; p < 16; p++) cm_res[p] = conv_at(cm_tile, p);
                            cm_cnt = 0; cm_d = 0; cm_phase = 1;
                        end
                    end else if (cm_cnt != 0) begin
                        cm_brk++;
                    end
                end
                1: begin
                    if (job_err) cm_phase = 0;
                    else if (!cm_hang) begin
                        if (cm_d == cm_delay) begin CONV_finish = 1'b1; cm_phase = 2; end
                        else cm_d++;
                    end
                end
                2: begin
                    CONV_finish = 1'b0; CONV_oData = 20'sh5A5A5; cm_j = 0; cm_phase = 3;
                end
                default: begin
                    if (cm_j < 16) begin CONV_oData = 20'(cm_res[cm_j]); cm_j++; end
                    else begin CONV_oData = 20'sh5A5A5; cm_phase = 0; end
                end
            endcase
        end
    end

    // Output monitor and activity counters.
    int exp_a_q [$];
    int exp_d_q [$];
    int rd_cnt = 0, st_cnt = 0, we_cnt = 0, done_cnt = 0, err_cnt = 0;
    int exp_rd = 0, addr_err = 0, done_cyc = 0, err_cyc = 0, t0 = 0;
    always @(negedge clk) begin
        if (out_we) begin
            we_cnt++;
            if (exp_d_q.size() == 0) check("write_unexpected", 1, 0);
            else begin
                check("out_addr", out_addr, exp_a_q.pop_front());
                check("out_data", out_data, exp_d_q.pop_front());
            end
        end
        if (in_rd_en) begin
            if (int'(in_addr) != exp_rd) addr_err++;
            exp_rd++; rd_cnt++;
        end
        if (CONV_start) st_cnt++;
        if (job_done) begin done_cnt++; done_cyc = cyc; end
        if (job_err)  begin err_cnt++;  err_cyc  = cyc; end
    end

    task automatic fill(input int nch, input int mode);
        for (int ch = 0; ch < nch; ch++)
            for (int k = 0; k < 36; k++) begin
                int v;
                if (mode == 0) v = k - 18 + ch;
                else if (mode == 1) v = int'($urandom_range(0, 255)) - 128;
                else v = -128;
                mem[ch*36 + k] = 8'(v);
            end
    endtask

    task automatic set_kern(input int mode, input int val);
        for (int i = 0; i < 9; i++) kern[i] = (mode == 1) ? int'($urandom_range(0, 255)) - 128 : val;
    endtask

    task automatic push_expected(input int nch);
        int acc [16];
        int t [36];
        for (int p = 0; p < 16; p++) acc[p] = 0;
        for (int ch = 0; ch < nch; ch++) begin
            for (int k = 0; k < 36; k++) t[k] = int'(mem[ch*36 + k]);
            for (int p = 0; p < 16; p++) acc[p] += conv_at(t, p);
        end
        for (int p = 0; p < 16; p++) begin
            exp_a_q.push_back(p);
            exp_d_q.push_back(sat20(acc[p]));
        end
    endtask

    task automatic start_job(input string tag, input int nch, input bit exp_busy);
        @(posedge clk); #1;
        rd_cnt = 0; st_cnt = 0; we_cnt = 0; done_cnt = 0; err_cnt = 0;
        exp_rd = 0; addr_err = 0; cm_brk = 0;
        job_nch = 5'(nch); job_start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        job_start = 1'b0;
        check({tag, "_busy"}, job_busy, exp_busy);
    endtask

    task automatic wait_end(input string tag, input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (job_done || job_err) got = 1;
        end
        check({tag, "_ended"}, got, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic end_checks(input string tag, input int e_done, input int e_rd, input int e_we, input int lat);
        check({tag, "_done_cnt"}, done_cnt, e_done);
        check({tag, "_err_cnt"}, err_cnt, 1 - e_done);
        check({tag, "_rd_cnt"}, rd_cnt, e_rd);
        check({tag, "_stream_cnt"}, st_cnt, e_rd);
        check({tag, "_we_cnt"}, we_cnt, e_we);
        check({tag, "_addr_err"}, addr_err, 0);
        check({tag, "_burst_gap"}, cm_brk, 0);
        check({tag, "_sb_left"}, exp_d_q.size(), 0);
        check({tag, "_latency"}, (e_done == 1) ? done_cyc - t0 : err_cyc - t0, lat);
    endtask

    function automatic logic [47:0] out_vec();
        return {job_busy, job_done, job_err, in_rd_en, in_addr, CONV_start, CONV_iData,
                out_we, out_addr, out_data};
    endfunction

    initial begin
        #400000;
        $display("FAIL global_timeout: got cycle %0d expected end of test", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", out_vec(), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_outputs", out_vec(), 0);

        // One channel, ramp tile, all-ones kernel; spurious finish while streaming.
        fill(1, 0); set_kern(0, 1); cm_delay = 3; cm_spur = 1;
        push_expected(1);
        start_job("ramp1", 1, 1);
        wait_end("ramp1", 400);
        end_checks("ramp1", 1, 36, 16, 72 + 4);
        cm_spur = 0;

        // Four random channels, random kernel, minimum wait.
        fill(4, 1); set_kern(1, 0); cm_delay = 0;
        push_expected(4);
        start_job("rand4", 4, 1);
        wait_end("rand4", 800);
        end_checks("rand4", 1, 144, 16, 4 * 56 + 16 + 1);

        // Sixteen channels saturating positive, then negative.
        fill(16, 2); set_kern(0, -128); cm_delay = 2;
        push_expected(16);
        start_job("satpos", 16, 1);
        wait_end("satpos", 2000);
        end_checks("satpos", 1, 576, 16, 16 * 58 + 16 + 1);
        set_kern(0, 127);
        push_expected(16);
        start_job("satneg", 16, 1);
        wait_end("satneg", 2000);
        end_checks("satneg", 1, 576, 16, 16 * 58 + 16 + 1);

        // Invalid channel counts.
        start_job("nch0", 0, 0);
        wait_end("nch0", 20);
        end_checks("nch0", 0, 0, 0, 1);
        start_job("nch17", 17, 0);
        wait_end("nch17", 20);
        end_checks("nch17", 0, 0, 0, 1);

        // CONV never finishes, then finishes on the final allowed WAIT cycle.
        fill(1, 1); cm_hang = 1;
        start_job("tmo", 1, 1);
        wait_end("tmo", 600);
        end_checks("tmo", 0, 36, 0, 1 + 2 + 36 + 256);
        cm_hang = 0; cm_delay = 255;
        push_expected(1);
        start_job("lastfin", 1, 1);
        wait_end("lastfin", 600);
        end_checks("lastfin", 1, 36, 16, 72 + 256);

        // Reset in the middle of channel 2, then a clean one-channel job.
        fill(3, 1); set_kern(1, 0); cm_delay = 1;
        start_job("abort", 3, 1);
        for (int i = 0; i < 600 && st_cnt < 82; i++) @(posedge clk);
        check("abort_reached_ch2", st_cnt >= 82, 1);
        #1;
        reset = 1'b0;
        #1;
        check("abort_reset_outputs", out_vec(), 0);
        repeat (2) @(posedge clk);
        exp_a_q.delete(); exp_d_q.delete();
        #1;
        reset = 1'b1;
        fill(1, 1);
        push_expected(1);
        start_job("restart", 1, 1);
        repeat (20) @(posedge clk);
        #1;
        job_nch = 5'd2; job_start = 1'b1;
        @(posedge clk); #1;
        job_start = 1'b0;
        wait_end("restart", 400);
        end_checks("restart", 1, 36, 16, 72 + 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
